gamepad_event_queue: RTL

- Consumes the button status word produced by the SEGA gamepad poller.
- Debounces each button over successive poll samples and converts stable level changes into press/release events.
- Queues events in a FIFO that the CPU-side register interface drains; the Doom input layer reads key-down and key-up events from it.

---
 rtl/gamepad_pkg.sv | 41 ++++
 rtl/gamepad_event_queue_if.sv | 10 +
 rtl/gamepad_event_fifo.sv | 63 ++++++
 rtl/gamepad_event_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gamepad_pkg.sv
// Shared types for the gamepad event path: button indices, event layout,
// scanner states and an event builder.
package gamepad_pkg;

  typedef enum logic [3:0] {
    UP    = 4'd0,
    DOWN  = 4'd1,
    LEFT  = 4'd2,
    RIGHT = 4'd3,
    A     = 4'd4,
    B     = 4'd5,
    C     = 4'd6,
    START = 4'd7,
    MODE  = 4'd8,
    X     = 4'd9,
    Y     = 4'd10,
    Z     = 4'd11
  } btn_idx_e;

  localparam int EV_PRESS_BIT = 7;

  typedef struct packed {
    logic       press;
    logic [2:0] rsvd;
    logic [3:0] idx;
  } gp_event_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  function automatic gp_event_t make_event(input logic press, input logic [3:0] idx);
    gp_event_t ev;
    ev.press = press;
    ev.rsvd  = 3'b000;
    ev.idx   = idx;
    return ev;
  endfunction

endpackage

// File: rtl/gamepad_event_queue_if.sv
// Event stream from the queue to the CPU-side register block.
// master = queue (drives head/valid), slave = consumer (drives ready).
interface gamepad_event_queue_if;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic       ev_ready;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/gamepad_event_fifo.sv
// First-word-fall-through FIFO: head is the oldest entry whenever not empty.
// A pop on empty is ignored; a push on full is taken only alongside a pop.
module gamepad_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/gamepad_event_queue.sv
// Debounces the gamepad poller status word, turns accepted level changes into
// press/release events via an ascending-index scanner, and queues them in an
// FWFT FIFO. Optional macro GP_EVENT_IRQ_EN adds a registered irq output.
module gamepad_event_queue
  import gamepad_pkg::*;
#(
  parameter int NUM_BTNS         = 12,
  parameter int DEBOUNCE_SAMPLES = 2,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   gp_status,
  input  logic                          sample_stb,
  gamepad_event_queue_if.master         ev,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [NUM_BTNS-1:0]           btn_state
`ifdef GP_EVENT_IRQ_EN
  ,
  output logic                          irq
`endif
);
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_SAMPLES);
  localparam logic [3:0] LAST_IDX = 4'(NUM_BTNS - 1);

  logic [NUM_BTNS-1:0] raw;
  logic                unused_status;
  logic [3:0]          cnt_q [NUM_BTNS];
  logic [3:0]          cnt_d [NUM_BTNS];
  logic [NUM_BTNS-1:0] btn_q, btn_d, pend_q, pend_d, pend_set, pend_clr;
  scan_state_e         state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic                push;
  gp_event_t           push_ev;
  logic                ovf_q, ovf_d;
  logic                fifo_full, fifo_empty, pop_eff, drop;
  logic [7:0]          fifo_head;

  assign raw           = gp_status[NUM_BTNS-1:0];
  assign unused_status = ^gp_status[31:NUM_BTNS];

  // Per-button debounce: a run of DEBOUNCE_SAMPLES differing strobes flips the level.
  always_comb begin
    btn_d    = btn_q;
    pend_set = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample_stb) begin
        if (raw[i] != btn_q[i]) begin
          if (cnt_q[i] + 4'd1 == DB_LIMIT) begin
            btn_d[i]    = ~btn_q[i];
            cnt_d[i]    = '0;
            pend_set[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Scanner: walks every index once per pass, pushing at most one event per cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    push     = 1'b0;
    pend_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (pend_q[idx_q]) begin
          push            = 1'b1;
          pend_clr[idx_q] = 1'b1;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A debounce set in the same cycle as a scanner clear must survive.
  assign pend_d  = (pend_q & ~pend_clr) | pend_set;
  assign push_ev = make_event(btn_q[idx_q], idx_q);

  gamepad_event_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_ev),
    .pop       (ev.ev_ready),
    .head      (fifo_head),
    .count     (ev_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop_eff     = ev.ev_ready && !fifo_empty;
  assign drop        = push && fifo_full && !pop_eff;
  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_data  = fifo_head;
  assign btn_state   = btn_q;
  assign overflow    = ovf_q;

  // Sticky overflow: a drop in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  // State registers; reset discards pending work and debounce history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q   <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= '0;
    end else begin
      btn_q   <= btn_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef GP_EVENT_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt request follows queue occupancy or overflow one cycle later.
  always_comb begin
    irq_d = (ev_count != '0) || ovf_q;
  end

  // Interrupt register.
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule
